// File: rtl/thread_fetch_sched.sv
// thread_fetch_sched: per-thread PC file and round-robin fetch selector; FETCH_SKIP_STALLED_EN skips ineligible threads.
// One-cycle registered outputs; stallF freezes selection and outputs while redirect/halt still update thread state.
module thread_fetch_sched #(
  parameter int          NTHREADS  = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STRIDE = 32'h0000_0100,
  localparam int         TW        = $clog2(NTHREADS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stallF,
  input  logic [NTHREADS-1:0] thread_ready,
  input  logic                redirect_valid,
  input  logic [TW-1:0]       redirect_tid,
  input  logic [31:0]         redirect_pc,
  input  logic                halt_valid,
  input  logic [TW-1:0]       halt_tid,
  output logic [31:0]         PCF,
  output logic [TW-1:0]       tidF,
  output logic                validF,
  output logic                all_halted
);

  logic [31:0]         pcQ [NTHREADS];
  logic [NTHREADS-1:0] activeQ;
  logic [TW-1:0]       rrQ;

  logic [NTHREADS-1:0] activeNext;
  logic [NTHREADS-1:0] eligible;
  logic [TW-1:0]       selTid;
  logic                selFound;
  logic                issue;
  logic                redirHitSel;
  logic [31:0]         issuePc;
  logic [TW-1:0]       rrNext;
`ifdef FETCH_SKIP_STALLED_EN
  logic [TW-1:0]       cand;
`endif

  // A same-cycle halt already removes the thread from this cycle's selection.
  always_comb begin
    activeNext = activeQ;
    if (halt_valid) begin
      activeNext[halt_tid] = 1'b0;
    end
    eligible = activeNext & thread_ready;
  end

  always_comb begin
    selTid   = rrQ;
    selFound = 1'b0;
`ifdef FETCH_SKIP_STALLED_EN
    cand = rrQ;
    for (int i = 0; i < NTHREADS; i++) begin
      cand = rrQ + TW'(i);
      if (!selFound && eligible[cand]) begin
        selFound = 1'b1;
        selTid   = cand;
      end
    end
`else
    selFound = eligible[rrQ];
`endif
  end

  always_comb begin
    issue       = !stallF && selFound;
    redirHitSel = redirect_valid && (redirect_tid == selTid);
    issuePc     = redirHitSel ? redirect_pc : pcQ[selTid];
    if (stallF) begin
      rrNext = rrQ;
    end else if (selFound) begin
      rrNext = selTid + TW'(1);
    end else begin
`ifdef FETCH_SKIP_STALLED_EN
      rrNext = rrQ;
`else
      rrNext = rrQ + TW'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTHREADS; i++) begin
        pcQ[i] <= RESET_PC + 32'(i) * PC_STRIDE;
      end
      activeQ    <= '1;
      rrQ        <= '0;
      PCF        <= RESET_PC;
      tidF       <= '0;
      validF     <= 1'b0;
      all_halted <= 1'b0;
    end else begin
      // The issue path already folds in a same-thread redirect, so it takes priority here.
      for (int i = 0; i < NTHREADS; i++) begin
        if (issue && (selTid == TW'(i))) begin
          pcQ[i] <= issuePc + 32'd4;
        end else if (redirect_valid && (redirect_tid == TW'(i))) begin
          pcQ[i] <= redirect_pc;
        end
      end
      activeQ    <= activeNext;
      rrQ        <= rrNext;
      all_halted <= ~|activeNext;
      if (!stallF) begin
        validF <= issue;
        if (issue) begin
          PCF  <= issuePc;
          tidF <= selTid;
        end
      end
    end
  end

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Scoreboard bench for thread_fetch_sched: directed test-plan sequences plus randomised traffic.
module tb_thread_fetch_sched;
  localparam int NT = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          stallF;
  logic [NT-1:0] thread_ready;
  logic          redirect_valid;
  logic [TW-1:0] redirect_tid;
  logic [31:0]   redirect_pc;
  logic          halt_valid;
  logic [TW-1:0] halt_tid;
  logic [31:0]   PCF;
  logic [TW-1:0] tidF;
  logic          validF;
  logic          all_halted;

  always #5 clk = ~clk;

  thread_fetch_sched #(
    .NTHREADS (NT),
    .RESET_PC (32'h0000_0000),
    .PC_STRIDE(32'h0000_0100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stallF        (stallF),
    .thread_ready  (thread_ready),
    .redirect_valid(redirect_valid),
    .redirect_tid  (redirect_tid),
    .redirect_pc   (redirect_pc),
    .halt_valid    (halt_valid),
    .halt_tid      (halt_tid),
    .PCF           (PCF),
    .tidF          (tidF),
    .validF        (validF),
    .all_halted    (all_halted)
  );

  typedef struct {
    logic [31:0]   pc;
    logic [TW-1:0] tid;
    logic          v;
    logic          ah;
  } expT;

  expT sbQ[$];
  int  errCnt = 0;
  int  chkCnt = 0;

  logic [31:0]   mPc [NT];
  logic [NT-1:0] mAct;
  logic [TW-1:0] mRr;
  logic [31:0]   mPCF;
  logic [TW-1:0] mTid;
  logic          mV;
  logic          mAh;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    chkCnt++;
    if (got !== want) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle, predict the post-edge outputs, then compare after the edge.
  task automatic cyc(input logic rst, input logic st, input logic [NT-1:0] rdy,
                     input logic rv, input logic [TW-1:0] rt, input logic [31:0] rp,
                     input logic hv, input logic [TW-1:0] ht);
    logic [NT-1:0] act;
    logic [NT-1:0] elig;
    logic          found;
    int            sel;
    logic [31:0]   base;
    expT           e;
    reset = rst; stallF = st; thread_ready = rdy;
    redirect_valid = rv; redirect_tid = rt; redirect_pc = rp;
    halt_valid = hv; halt_tid = ht;
    if (rst) begin
      for (int i = 0; i < NT; i++) mPc[i] = 32'h100 * i;
      mAct = '1; mRr = '0; mPCF = 32'h0; mTid = '0; mV = 1'b0; mAh = 1'b0;
    end else begin
      act = mAct;
      if (hv) act[ht] = 1'b0;
      elig  = act & rdy;
      found = 1'b0;
      sel   = int'(mRr);
`ifdef FETCH_SKIP_STALLED_EN
      for (int k = 0; k < NT; k++) begin
        if (!found && elig[(int'(mRr) + k) % NT]) begin
          found = 1'b1;
          sel   = (int'(mRr) + k) % NT;
        end
      end
`else
      found = elig[mRr];
`endif
      base = (rv && int'(rt) == sel) ? rp : mPc[sel];
      if (rv) mPc[rt] = rp;
      if (!st) begin
        if (found) begin
          mPCF = base; mTid = TW'(sel); mV = 1'b1;
          mPc[sel] = base + 32'd4;
          mRr = TW'((sel + 1) % NT);
        end else begin
          mV = 1'b0;
`ifndef FETCH_SKIP_STALLED_EN
          mRr = TW'((int'(mRr) + 1) % NT);
`endif
        end
      end
      mAct = act;
      mAh  = (act == '0);
    end
    e.pc = mPCF; e.tid = mTid; e.v = mV; e.ah = mAh;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      check("sb_pcf", PCF, e.pc);
      check("sb_tidf", 32'(tidF), 32'(e.tid));
      check("sb_validf", 32'(validF), 32'(e.v));
      check("sb_all_halted", 32'(all_halted), 32'(e.ah));
    end
  endtask

  task automatic run(input logic [NT-1:0] rdy);
    cyc(1'b0, 1'b0, rdy, 1'b0, '0, 32'h0, 1'b0, '0);
  endtask

  task automatic doReset();
    cyc(1'b1, 1'b0, '1, 1'b0, '0, 32'h0, 1'b0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FETCH_SKIP_STALLED_EN
    int t2Tid [5] = '{0, 2, 3, 0, 2};
    int t2Vld [5] = '{1, 1, 1, 1, 1};
    int t2Pc  [5] = '{32'h000, 32'h200, 32'h300, 32'h004, 32'h204};
`else
    int t2Tid [5] = '{0, 0, 2, 3, 0};
    int t2Vld [5] = '{1, 0, 1, 1, 1};
    int t2Pc  [5] = '{32'h000, 32'h000, 32'h200, 32'h300, 32'h004};
`endif

    // Reset state
    doReset();
    doReset();
    check("rst_pcf", PCF, 32'h0);
    check("rst_tidf", 32'(tidF), 32'd0);
    check("rst_validf", 32'(validF), 32'd0);
    check("rst_all_halted", 32'(all_halted), 32'd0);

    // Plain rotation, all threads ready
    for (int k = 0; k < 8; k++) begin
      run('1);
      check("rot_tid", 32'(tidF), 32'(k % 4));
      check("rot_pc", PCF, 32'h100 * (k % 4) + 32'd4 * (k / 4));
      check("rot_valid", 32'(validF), 32'd1);
    end

    // Thread 1 not ready
    doReset();
    for (int k = 0; k < 5; k++) begin
      run(4'b1101);
      check("rdy_tid", 32'(tidF), 32'(t2Tid[k]));
      check("rdy_valid", 32'(validF), 32'(t2Vld[k]));
      check("rdy_pc", PCF, 32'(t2Pc[k]));
    end

    // Redirect in the same cycle the thread issues
    doReset();
    run('1);
    run('1);
    cyc(1'b0, 1'b0, '1, 1'b1, 2'd2, 32'h4000, 1'b0, '0);
    check("redir_same_pc", PCF, 32'h4000);
    check("redir_same_tid", 32'(tidF), 32'd2);
    run('1); run('1); run('1);
    run('1);
    check("redir_next_pc", PCF, 32'h4004);
    check("redir_next_tid", 32'(tidF), 32'd2);

    // Stall for three cycles with a redirect applied during the stall
    cyc(1'b0, 1'b1, '1, 1'b1, 2'd1, 32'h800, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc(1'b0, 1'b1, '1, 1'b0, '0, 32'h0, 1'b0, '0);
      check("stall_pc", PCF, 32'h4004);
      check("stall_tid", 32'(tidF), 32'd2);
      check("stall_valid", 32'(validF), 32'd1);
    end
    run('1);
    check("unstall_tid3", 32'(tidF), 32'd3);
    run('1);
    check("unstall_tid0_pc", PCF, 32'h008);
    run('1);
    check("unstall_tid1_pc", PCF, 32'h800);
    check("unstall_tid1", 32'(tidF), 32'd1);

    // Halt every thread, one with a simultaneous redirect
    cyc(1'b0, 1'b0, '1, 1'b0, '0, 32'h0, 1'b1, 2'd0);
    cyc(1'b0, 1'b0, '1, 1'b0, '0, 32'h0, 1'b1, 2'd1);
    cyc(1'b0, 1'b0, '1, 1'b1, 2'd2, 32'h9000, 1'b1, 2'd2);
    check("halt_partial_all", 32'(all_halted), 32'd0);
    cyc(1'b0, 1'b0, '1, 1'b0, '0, 32'h0, 1'b1, 2'd3);
    check("halt_last_valid", 32'(validF), 32'd0);
    check("halt_last_all", 32'(all_halted), 32'd1);
    for (int k = 0; k < 3; k++) begin
      run('1);
      check("halted_valid", 32'(validF), 32'd0);
    end
    doReset();
    check("halt_rst_all", 32'(all_halted), 32'd0);
    run('1);
    check("resume_pc", PCF, 32'h0);
    check("resume_tid", 32'(tidF), 32'd0);
    check("resume_valid", 32'(validF), 32'd1);

    // PC wraps past 2^32
    cyc(1'b0, 1'b0, '1, 1'b1, 2'd3, 32'hFFFF_FFFC, 1'b0, '0);
    run('1);
    run('1);
    check("wrap_top_pc", PCF, 32'hFFFF_FFFC);
    check("wrap_top_tid", 32'(tidF), 32'd3);
    run('1); run('1); run('1);
    run('1);
    check("wrap_zero_pc", PCF, 32'h0000_0000);
    check("wrap_zero_tid", 32'(tidF), 32'd3);

    // Random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 3) == 0),
          NT'($urandom_range(0, 15)),
          ($urandom_range(0, 4) == 0),
          TW'($urandom_range(0, NT - 1)),
          {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
          ($urandom_range(0, 15) == 0),
          TW'($urandom_range(0, NT - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
